// File: rtl/sudoku_group_controller.sv
// rtl/sudoku_group_controller.sv - one elimination pass over a 9-cell sudoku group
// Reads each cell's value over the shared bus, broadcasts the unused-digit mask, then promotes singletons.
module sudoku_group_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [9:1] bus_in,
    input  logic [8:0] cell_solved,
    input  logic [8:0] cell_singleton,
    output logic [9:1] bus_out,
    output logic       bus_drive,
    output logic [1:0] cell_address,
    output logic [8:0] cell_oe,
    output logic       cell_we,
    output logic       latch_valid,
    output logic       latch_singleton,
    output logic       busy,
    output logic       done,
    output logic       conflict,
    output logic       changed
);
    typedef enum logic [2:0] {IDLE, READ, ELIM, SINGLE, DONE} state_t;

    state_t     state_q, state_d;
    logic [3:0] index_q, index_d;
    logic [9:1] mask_q, mask_d;
    logic [9:1] bus_out_q, bus_out_d;
    logic [8:0] cell_oe_q, cell_oe_d;
    logic       bus_drive_q, bus_drive_d;
    logic       latch_valid_q, latch_valid_d;
    logic       latch_singleton_q, latch_singleton_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       conflict_q, conflict_d;
    logic       changed_q, changed_d;

    // Only the value register is ever read, and this block never writes cells.
    assign cell_address    = 2'd0;
    assign cell_we         = 1'b0;
    assign bus_out         = bus_out_q;
    assign bus_drive       = bus_drive_q;
    assign cell_oe         = cell_oe_q;
    assign latch_valid     = latch_valid_q;
    assign latch_singleton = latch_singleton_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign conflict        = conflict_q;
    assign changed         = changed_q;

    // Strobes are computed for the next state so they are registered yet aligned with it.
    always_comb begin
        state_d           = state_q;
        index_d           = index_q;
        mask_d            = mask_q;
        conflict_d        = conflict_q;
        changed_d         = changed_q;
        bus_out_d         = 9'h000;
        cell_oe_d         = 9'h000;
        bus_drive_d       = 1'b0;
        latch_valid_d     = 1'b0;
        latch_singleton_d = 1'b0;
        done_d            = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = READ;
                    index_d    = 4'd0;
                    mask_d     = 9'h000;
                    conflict_d = 1'b0;
                    changed_d  = 1'b0;
                    cell_oe_d  = 9'h001;
                end
            end
            READ: begin
                mask_d = mask_q | bus_in;
                if ((bus_in & mask_q) != 9'h000) begin
                    conflict_d = 1'b1;
                end
                if (index_q == 4'd8) begin
                    state_d       = ELIM;
                    bus_drive_d   = 1'b1;
                    latch_valid_d = 1'b1;
                    bus_out_d     = ~(mask_q | bus_in);
                end else begin
                    index_d   = index_q + 4'd1;
                    cell_oe_d = 9'h001 << (index_q + 4'd1);
                end
            end
            ELIM: begin
                state_d           = SINGLE;
                latch_singleton_d = 1'b1;
            end
            SINGLE: begin
                state_d   = DONE;
                changed_d = |(cell_singleton & ~cell_solved);
                done_d    = 1'b1;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q           <= IDLE;
            index_q           <= 4'd0;
            mask_q            <= 9'h000;
            bus_out_q         <= 9'h000;
            cell_oe_q         <= 9'h000;
            bus_drive_q       <= 1'b0;
            latch_valid_q     <= 1'b0;
            latch_singleton_q <= 1'b0;
            busy_q            <= 1'b0;
            done_q            <= 1'b0;
            conflict_q        <= 1'b0;
            changed_q         <= 1'b0;
        end else begin
            state_q           <= state_d;
            index_q           <= index_d;
            mask_q            <= mask_d;
            bus_out_q         <= bus_out_d;
            cell_oe_q         <= cell_oe_d;
            bus_drive_q       <= bus_drive_d;
            latch_valid_q     <= latch_valid_d;
            latch_singleton_q <= latch_singleton_d;
            busy_q            <= busy_d;
            done_q            <= done_d;
            conflict_q        <= conflict_d;
            changed_q         <= changed_d;
        end
    end
endmodule

// File: tb/tb_sudoku_group_controller.sv
// tb/tb_sudoku_group_controller.sv - directed self-checking bench for sudoku_group_controller
module tb_sudoku_group_controller;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [9:1] bus_in;
    logic [8:0] cell_solved = 9'h000;
    logic [8:0] cell_singleton = 9'h000;
    logic [9:1] bus_out;
    logic       bus_drive;
    logic [1:0] cell_address;
    logic [8:0] cell_oe;
    logic       cell_we;
    logic       latch_valid;
    logic       latch_singleton;
    logic       busy;
    logic       done;
    logic       conflict;
    logic       changed;

    logic [9:1] cell_val [9];
    int passed = 0;
    int total  = 0;
    int failed = 0;

    sudoku_group_controller dut (
        .clk(clk), .reset(reset), .start(start), .bus_in(bus_in),
        .cell_solved(cell_solved), .cell_singleton(cell_singleton),
        .bus_out(bus_out), .bus_drive(bus_drive), .cell_address(cell_address),
        .cell_oe(cell_oe), .cell_we(cell_we), .latch_valid(latch_valid),
        .latch_singleton(latch_singleton), .busy(busy), .done(done),
        .conflict(conflict), .changed(changed)
    );

    always #5 clk = ~clk;

    // Cell model: the enabled cell places its value on the shared bus.
    always_comb begin
        bus_in = 9'h000;
        for (int i = 0; i < 9; i++) begin
            if (cell_oe[i]) bus_in = bus_in | cell_val[i];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_cells(input logic [9:1] v0, v1, v2, v3, v4, v5, v6, v7, v8);
        cell_val[0] = v0; cell_val[1] = v1; cell_val[2] = v2;
        cell_val[3] = v3; cell_val[4] = v4; cell_val[5] = v5;
        cell_val[6] = v6; cell_val[7] = v7; cell_val[8] = v8;
    endtask

    // Called just after a posedge; returns at the negedge of the done cycle.
    task automatic run_pass(output int done_cyc, output logic [9:1] elim_bus,
                            output int lv_cnt, output int ls_cnt, output int bad,
                            output logic conf1);
        int cyc;
        logic [8:0] exp_oe;
        done_cyc = 0; elim_bus = 9'h000; lv_cnt = 0; ls_cnt = 0; bad = 0; conf1 = 1'bx;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 0;
        while (done_cyc == 0 && cyc < 20) begin
            @(negedge clk);
            cyc++;
            exp_oe = (cyc >= 1 && cyc <= 9) ? (9'h001 << (cyc - 1)) : 9'h000;
            if (cyc == 1) conf1 = conflict;
            if (cell_oe !== exp_oe || cell_address !== 2'd0 || cell_we !== 1'b0) bad++;
            if (bus_drive !== (cyc == 10) || latch_singleton !== (cyc == 11)) bad++;
            if ((latch_valid || latch_singleton || bus_drive) && cell_oe != 9'h000) bad++;
            if (busy !== 1'b1) bad++;
            if (latch_valid) lv_cnt++;
            if (latch_singleton) ls_cnt++;
            if (bus_drive) elim_bus = bus_out;
            if (done) done_cyc = cyc;
        end
    endtask

    initial begin
        int dc, lv, ls, bad, ndone, first_done, second_done;
        logic [9:1] eb;
        logic c1;
        logic busy13;

        set_cells(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_strobes", {cell_oe, bus_drive, latch_valid, latch_singleton}, 0);
        check("rst_bus_out", bus_out, 0);
        check("rst_addr_we", {cell_address, cell_we}, 0);
        check("rst_flags", {conflict, changed}, 0);

        // Reset wins over a simultaneous start.
        start = 1'b1;
        @(posedge clk);
        #1;
        check("rst_prio_busy", busy, 0);
        start = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;

        set_cells(9'h001, 9'h002, 9'h004, 0, 0, 0, 0, 0, 0);
        run_pass(dc, eb, lv, ls, bad, c1);
        check("p1_done_cyc", dc, 12);
        check("p1_elim_bus", eb, 9'h1F8);
        check("p1_latch_valid_cnt", lv, 1);
        check("p1_latch_single_cnt", ls, 1);
        check("p1_sequence", bad, 0);
        check("p1_conflict", conflict, 0);
        @(negedge clk);
        check("p1_idle_busy", {busy, done, cell_oe, bus_drive, latch_valid, latch_singleton}, 0);
        @(posedge clk);
        #1;

        set_cells(9'h001, 0, 0, 9'h010, 0, 0, 0, 9'h010, 9'h100);
        run_pass(dc, eb, lv, ls, bad, c1);
        check("p2_done_cyc", dc, 12);
        check("p2_conflict", conflict, 1);
        check("p2_elim_bus", eb, 9'h0EE);
        repeat (4) @(negedge clk);
        check("p2_conflict_hold", conflict, 1);
        @(posedge clk);
        #1;

        set_cells(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cell_singleton = 9'h004;
        cell_solved    = 9'h000;
        run_pass(dc, eb, lv, ls, bad, c1);
        check("p3_conflict_cleared_at_start", c1, 0);
        check("p3_elim_bus_all_zero", eb, 9'h1FF);
        check("p3_sequence", bad, 0);
        check("p3_changed", changed, 1);
        check("p3_conflict", conflict, 0);
        repeat (3) @(negedge clk);
        check("p3_changed_hold", changed, 1);
        @(posedge clk);
        #1;

        cell_solved = 9'h004;
        run_pass(dc, eb, lv, ls, bad, c1);
        check("p4_changed_solved", changed, 0);
        check("p4_done_cyc", dc, 12);
        cell_singleton = 9'h000;
        cell_solved    = 9'h000;
        @(posedge clk);
        #1;

        // Continuous start: done at 12, one IDLE cycle, next done 13 cycles later.
        start = 1'b1;
        ndone = 0; first_done = 0; second_done = 0; busy13 = 1'bx;
        @(posedge clk);
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (c == 13) busy13 = busy;
            if (done) begin
                ndone++;
                if (ndone == 1) first_done = c;
                if (ndone == 2) second_done = c;
            end
        end
        #1 start = 1'b0;
        check("b2b_done_count", ndone, 2);
        check("b2b_first_done", first_done, 12);
        check("b2b_second_done", second_done, 25);
        check("b2b_idle_gap_busy", busy13, 0);
        repeat (20) @(posedge clk);
        #1;

        // Reset mid-READ at index 4.
        set_cells(9'h001, 9'h002, 9'h004, 9'h008, 9'h010, 0, 0, 0, 0);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_oe_index4", cell_oe, 9'h010);
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_strobes", {cell_oe, bus_drive, latch_valid, latch_singleton, done}, 0);
        check("mid_rst_bus_out", bus_out, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        run_pass(dc, eb, lv, ls, bad, c1);
        check("post_rst_done_cyc", dc, 12);
        check("post_rst_elim_bus", eb, 9'h1E0);
        check("post_rst_sequence", bad, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
